// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads a combinational
// big-endian word memory, buffers words in a small in-order queue and hands
// {pc, instr} to decode over valid/ready. Redirects flush the queue; a bad
// fetch or redirect address parks the controller in a sticky fault state.
module instr_fetch_ctrl #(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   MEM_BYTES = 128,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter int unsigned   QDEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_pc,
  output logic          fault
);

  localparam int unsigned   CW   = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD   = CW'(QDEPTH);
  localparam int unsigned   LAST = MEM_BYTES - 4;

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] fetch_pc, pc_nx;
  logic [AW-1:0] q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] wr_idx;
  logic          deq, enq, flush;
  logic          pc_good, tgt_good;

  // A word fetch is legal only when aligned and fully inside the memory.
  function automatic logic addr_good(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && (32'(a) <= LAST);
  endfunction

  assign pc_good   = addr_good(fetch_pc);
  assign tgt_good  = addr_good(redirect_pc);
  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_pc    = q_pc[0];
  assign out_instr = q_instr[0];
  assign fault     = (state == FAULT);
  assign wr_idx    = count - CW'(deq);

  // Next state, next PC and queue push/pop decisions; redirect overrides all.
  always_comb begin
    state_nx = state;
    pc_nx    = fetch_pc;
    deq      = 1'b0;
    enq      = 1'b0;
    flush    = 1'b0;
    if (state != IDLE) deq = out_valid && out_ready;
    unique case (state)
      IDLE:  state_nx = RUN;
      RUN: begin
        if (!pc_good) begin
          state_nx = FAULT;
        end else begin
          enq = (count < QD) || deq;
          if (halt_req) state_nx = HALT;
        end
      end
      HALT:  if (!halt_req) state_nx = RUN;
      FAULT: state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
    if (enq) pc_nx = fetch_pc + AW'(4);
    if ((state != IDLE) && redirect_valid) begin
      flush = 1'b1;
      deq   = 1'b0;
      enq   = 1'b0;
      pc_nx = redirect_pc;
      if (!tgt_good)     state_nx = FAULT;
      else if (halt_req) state_nx = HALT;
      else               state_nx = RUN;
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= pc_nx;
    end
  end

  // Shift queue with the head always in slot 0; slot 0 is left untouched when
  // the queue empties so the outputs hold the last head value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(enq) - CW'(deq);
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (enq && (CW'(i) == wr_idx)) begin
          q_pc[i]    <= fetch_pc;
          q_instr[i] <= imem_data;
        end else if (deq && (CW'(i + 1) < count)) begin
          q_pc[i]    <= q_pc[(i + 1 < QDEPTH) ? i + 1 : i];
          q_instr[i] <= q_instr[(i + 1 < QDEPTH) ? i + 1 : i];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_instr_fetch_ctrl;

  localparam int unsigned MEM_BYTES = 128;
  localparam int unsigned QDEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  assign imem_data = rd_word(imem_addr);

  instr_fetch_ctrl #(
    .AW(8),
    .MEM_BYTES(128),
    .RESET_PC(8'h00),
    .QDEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .fault(fault)
  );

  // Behavioural model: a queue of {pc, instr}, a PC and two mode flags.
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_shown;
  int unsigned m_pc;
  bit          m_armed, m_halt, m_fault;

  function automatic bit good(input int unsigned a);
    return (a % 4 == 0) && (a + 4 <= MEM_BYTES);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_shown = '0;
    m_pc    = 0;
    m_armed = 0;
    m_halt  = 0;
    m_fault = 0;
  endtask

  task automatic model_update();
    bit deq;
    if (!rst_n) return;
    if (!m_armed) begin
      m_armed = 1;
      return;
    end
    deq = (mq.size() > 0) && out_ready;
    if (redirect_valid) begin
      mq.delete();
      m_pc    = redirect_pc;
      m_fault = !good(m_pc);
      m_halt  = !m_fault && halt_req;
    end else begin
      if (deq) void'(mq.pop_front());
      if (!m_fault && !m_halt) begin
        if (!good(m_pc)) begin
          m_fault = 1;
        end else begin
          if (mq.size() < QDEPTH) begin
            mq.push_back({8'(m_pc), rd_word(8'(m_pc))});
            m_pc = (m_pc + 4) % 256;
          end
          m_halt = halt_req;
        end
      end else if (m_halt) begin
        m_halt = halt_req;
      end
    end
    if (mq.size() > 0) m_shown = mq[0];
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("fault",     32'(fault),     32'(m_fault));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("out_pc",    32'(out_pc),    32'(m_shown.pc));
    chk("out_instr", out_instr,      m_shown.instr);
  end

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int w = 0; w < 4; w++) begin
      logic [31:0] v;
      v = 32'h11111111 * (w + 1);
      mem[4*w]   = v[31:24];
      mem[4*w+1] = v[23:16];
      mem[4*w+2] = v[15:8];
      mem[4*w+3] = v[7:0];
    end
    model_reset();
    #2;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_pc",    32'(out_pc),    32'h0);
    chk("rst_instr", out_instr,      32'h0);
    chk("rst_fault", 32'(fault),     32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming after reset
    out_ready = 1'b1;
    step();
    chk("t1_idle_valid", 32'(out_valid), 32'h0);
    step();
    chk("t1_valid0", 32'(out_valid), 32'h1);
    chk("t1_pc0",    32'(out_pc),    32'h00);
    chk("t1_ins0",   out_instr,      32'h11111111);
    step();
    chk("t1_pc4",    32'(out_pc),    32'h04);
    chk("t1_ins4",   out_instr,      32'h22222222);
    step();
    chk("t1_ins8",   out_instr,      32'h33333333);
    step();
    chk("t1_pc12",   32'(out_pc),    32'h0c);
    chk("t1_ins12",  out_instr,      32'h44444444);

    // Backpressure fills the queue, then drains with no bubble
    do_reset();
    out_ready = 1'b0;
    repeat (5) step();
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_pc",    32'(out_pc),    32'h00);
    chk("t2_addr",  32'(imem_addr), 32'h08);
    out_ready = 1'b1;
    step();
    chk("t2_pc4", 32'(out_pc), 32'h04);
    step();
    chk("t2_pc8", 32'(out_pc), 32'h08);

    // Redirect while full flushes the queue
    out_ready = 1'b0;
    step();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", 32'(out_valid), 32'h0);
    step();
    chk("t3_valid", 32'(out_valid), 32'h1);
    chk("t3_pc",    32'(out_pc),    32'h40);

    // Misaligned redirect faults; good redirect recovers
    redirect_valid = 1'b1;
    redirect_pc = 8'h41;
    step();
    chk("t4_fault", 32'(fault),     32'h1);
    chk("t4_valid", 32'(out_valid), 32'h0);
    chk("t4_addr",  32'(imem_addr), 32'h41);
    redirect_pc = 8'h20;
    step();
    redirect_valid = 1'b0;
    chk("t4_clear", 32'(fault), 32'h0);
    step();
    chk("t4_pc",    32'(out_pc),    32'h20);
    chk("t4_valid2", 32'(out_valid), 32'h1);

    // Running off the end of memory
    redirect_valid = 1'b1;
    redirect_pc = 8'h74;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    chk("t5_pc124", 32'(out_pc),    32'h7c);
    chk("t5_v124",  32'(out_valid), 32'h1);
    step();
    chk("t5_fault", 32'(fault),     32'h1);
    chk("t5_addr",  32'(imem_addr), 32'h80);
    chk("t5_valid", 32'(out_valid), 32'h0);
    step();
    chk("t5_valid2", 32'(out_valid), 32'h0);

    // Halt freezes the PC while the queue drains
    redirect_valid = 1'b1;
    redirect_pc = 8'h00;
    step();
    redirect_valid = 1'b0;
    step();
    halt_req = 1'b1;
    repeat (3) step();
    chk("t6_addr",  32'(imem_addr), 32'h08);
    chk("t6_valid", 32'(out_valid), 32'h0);
    halt_req = 1'b0;
    step();
    step();
    chk("t6_resume_v",  32'(out_valid), 32'h1);
    chk("t6_resume_pc", 32'(out_pc),    32'h08);

    // Asynchronous reset mid-stream
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_addr",  32'(imem_addr), 32'h00);
    step();
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt_req = 1'b1;
      else halt_req = halt_req && ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, m_fault ? 3 : 40) == 0);
      if ($urandom_range(0, 5) == 0) redirect_pc = 8'($urandom);
      else redirect_pc = 8'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 500) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
